// File: rtl/flash_rom_cache.sv
// Direct-mapped 16-bit word cache in front of the DSPI flash reader.
// Hits are answered one cycle after the request; each miss becomes one
// flash transaction using the reader's edge-triggered cs / busy handshake,
// with a timed retry if the reader never acknowledges the cs edge.
module flash_rom_cache #(
   parameter int AW           = 22,
   parameter int IDX_BITS     = 4,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          req,
   input  logic [AW-1:0] addr,
   output logic          ack,
   output logic [15:0]   rdata,
   input  logic          flush,
   input  logic          flash_ready,
   input  logic          flash_busy,
   input  logic [15:0]   flash_dout,
   output logic          flash_cs,
   output logic [AW-1:0] flash_addr
);

   localparam int ENTRIES = 1 << IDX_BITS;
   localparam int TAG_W   = AW - IDX_BITS;
   localparam int CW      = $clog2(BUSY_TIMEOUT + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_START   = 3'd1;
   localparam logic [2:0] S_WAIT_HI = 3'd2;
   localparam logic [2:0] S_WAIT_LO = 3'd3;
   localparam logic [2:0] S_GAP     = 3'd4;

   logic [2:0]          state;
   logic [CW-1:0]       cnt;
   logic [CW-1:0]       cnt_nxt;
   logic                poison;

   logic [ENTRIES-1:0]  valid;
   logic [TAG_W-1:0]    tag_mem  [ENTRIES];
   logic [15:0]         data_mem [ENTRIES];

   logic [IDX_BITS-1:0] req_idx;
   logic [TAG_W-1:0]    req_tag;
   logic [IDX_BITS-1:0] fill_idx;
   logic [TAG_W-1:0]    fill_tag;
   logic                hit;
   logic                serve;
   logic                start_miss;
   logic                fill_done;
   logic                fill_we;

   assign req_idx  = addr[IDX_BITS-1:0];
   assign req_tag  = addr[AW-1:IDX_BITS];
   assign fill_idx = flash_addr[IDX_BITS-1:0];
   assign fill_tag = flash_addr[AW-1:IDX_BITS];

   // Lookup uses the registered valid bits, so a flush in the same cycle
   // does not hide a hit that is being served.
   assign hit        = valid[req_idx] && (tag_mem[req_idx] == req_tag);
   // The cycle after an ack the requester is still dropping req; ignore it.
   assign serve      = (state == S_IDLE) && req && !ack;
   // A busy reader may be doing its own init read; never start while busy.
   assign start_miss = serve && !hit && flash_ready && !flash_busy;
   assign fill_done  = (state == S_WAIT_LO) && !flash_busy;
   assign fill_we    = fill_done && !poison && !flush;
   assign cnt_nxt    = cnt + 1'b1;

   // Request sequencer: hit response, miss handshake, timeout retry.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         cnt        <= '0;
         poison     <= 1'b0;
         ack        <= 1'b0;
         rdata      <= '0;
         flash_cs   <= 1'b0;
         flash_addr <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every
         // branch below sees the values from before this clock edge.
         ack <= 1'b0;
         case (state)
            S_IDLE: begin
               if (serve && hit) begin
                  ack   <= 1'b1;
                  rdata <= data_mem[req_idx];
               end else if (start_miss) begin
                  flash_addr <= addr;
                  flash_cs   <= 1'b1;
                  cnt        <= '0;
                  poison     <= 1'b0;
                  state      <= S_START;
               end
            end
            S_START: begin
               if (flash_busy) begin
                  flash_cs <= 1'b0;
                  state    <= S_WAIT_HI;
               end else if (cnt_nxt == CW'(BUSY_TIMEOUT)) begin
                  flash_cs <= 1'b0;
                  cnt      <= '0;
                  state    <= S_GAP;
               end else begin
                  cnt <= cnt_nxt;
               end
            end
            S_WAIT_HI: begin
               if (flash_busy) state <= S_WAIT_LO;
            end
            S_WAIT_LO: begin
               if (!flash_busy) begin
                  rdata <= flash_dout;
                  ack   <= 1'b1;
                  state <= S_IDLE;
               end
            end
            S_GAP: begin
               // Two low cycles let the reader's input synchroniser see the
               // edge that follows.
               if (cnt == CW'(1)) begin
                  flash_cs <= 1'b1;
                  cnt      <= '0;
                  state    <= S_START;
               end else begin
                  cnt <= cnt_nxt;
               end
            end
            default: begin
               flash_cs <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
         if (flush && (state != S_IDLE)) poison <= 1'b1;
      end
   end

   // Valid bits: flush clears everything and takes priority over a fill.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid <= '0;
      end else if (flush) begin
         valid <= '0;
      end else if (fill_we) begin
         valid[fill_idx] <= 1'b1;
      end
   end

   // Tag and data storage, written on an unpoisoned fill.
   // NOTE: the arrays are not reset; the valid bits alone decide whether
   // their contents are ever used, which keeps them plain RAM.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= flash_dout;
      end
   end

endmodule

// File: tb/tb_flash_rom_cache.sv
// Directed testbench for flash_rom_cache with a behavioural flash reader.
module tb_flash_rom_cache;

   localparam int AW = 22;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          req = 1'b0;
   logic [AW-1:0] addr = '0;
   logic          flush = 1'b0;
   logic          flash_ready = 1'b0;
   logic          init_busy = 1'b0;
   logic          m_busy = 1'b0;
   logic          flash_busy;
   logic [15:0]   flash_dout = 16'h0000;
   logic          ack;
   logic [15:0]   rdata;
   logic          flash_cs;
   logic [AW-1:0] flash_addr;

   int checks = 0;
   int failures = 0;
   int cs_edges = 0;
   int ignore_edges = 0;
   int m_phase = 0;
   int m_cnt = 0;
   logic          cs_prev = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [AW-1:0] m_last_addr = '0;

   assign flash_busy = m_busy | init_busy;

   flash_rom_cache #(.AW(AW), .IDX_BITS(4), .BUSY_TIMEOUT(15)) dut (
      .clk(clk), .resetn(resetn), .req(req), .addr(addr), .ack(ack),
      .rdata(rdata), .flush(flush), .flash_ready(flash_ready),
      .flash_busy(flash_busy), .flash_dout(flash_dout),
      .flash_cs(flash_cs), .flash_addr(flash_addr)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] model_word(input logic [AW-1:0] a);
      if (a == 22'h000010) return 16'hBEEF;
      return a[15:0] ^ 16'hC35A;
   endfunction

   // Flash reader model: acts on the falling clock edge, away from the DUT.
   always @(negedge clk) begin
      if (!resetn) begin
         m_busy  = 1'b0;
         m_phase = 0;
         m_cnt   = 0;
         cs_prev = 1'b0;
      end else begin
         if (flash_cs && !cs_prev) begin
            cs_edges++;
            if (ignore_edges > 0) begin
               ignore_edges--;
            end else if (m_phase == 0) begin
               m_phase     = 1;
               m_cnt       = 0;
               m_addr      = flash_addr;
               m_last_addr = flash_addr;
            end
         end
         cs_prev = flash_cs;
         if (m_phase == 1) begin
            m_cnt++;
            if (m_cnt == 2) begin
               m_busy     = 1'b1;
               flash_dout = 16'hDEAD;
               m_cnt      = 0;
               m_phase    = 2;
            end
         end else if (m_phase == 2) begin
            m_cnt++;
            if (m_cnt == 3) begin
               checks++;
               if (flash_addr !== m_addr) begin
                  failures++;
                  $display("FAIL flash_addr_stable got=%h want=%h", flash_addr, m_addr);
               end
            end
            if (m_cnt == 6) begin
               m_busy     = 1'b0;
               flash_dout = model_word(m_addr);
               m_phase    = 0;
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_read(input logic [AW-1:0] a, output logic [15:0] d,
                          output int lat, output int edges);
      int e0;
      e0   = cs_edges;
      req  = 1'b1;
      addr = a;
      lat  = 0;
      d    = '0;
      for (int i = 0; i < 200; i++) begin
         tick();
         lat++;
         if (ack === 1'b1) begin
            d = rdata;
            break;
         end
      end
      req   = 1'b0;
      edges = cs_edges - e0;
      if (ack !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL read_timeout addr=%h no ack", a);
      end
   endtask

   task automatic wait_busy(input logic level);
      for (int i = 0; i < 100; i++) begin
         if (m_busy === level) break;
         tick();
      end
      checks++;
      if (m_busy !== level) begin
         failures++;
         $display("FAIL wait_busy got=%b want=%b", m_busy, level);
      end
   endtask

   task automatic test_reset();
      int cs_hi;
      int acks;
      int e0;
      #2;
      checks += 4;
      if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b want=0", ack); end
      if (rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", rdata); end
      if (flash_cs !== 1'b0) begin failures++; $display("FAIL reset_cs got=%b want=0", flash_cs); end
      if (flash_addr !== '0) begin failures++; $display("FAIL reset_addr got=%h want=0", flash_addr); end
      tick();
      tick();
      resetn = 1'b1;
      e0   = cs_edges;
      req  = 1'b1;
      addr = 22'h000123;
      cs_hi = 0;
      acks  = 0;
      for (int i = 0; i < 20; i++) begin
         init_busy = (i >= 5 && i < 15);
         tick();
         if (flash_cs === 1'b1) cs_hi++;
         if (ack === 1'b1) acks++;
      end
      checks += 2;
      if (cs_hi != 0) begin failures++; $display("FAIL not_ready_cs got=%0d want=0", cs_hi); end
      if (acks != 0) begin failures++; $display("FAIL not_ready_ack got=%0d want=0", acks); end
      init_busy   = 1'b0;
      flash_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (ack === 1'b1) break;
      end
      checks += 3;
      if (ack !== 1'b1 || rdata !== model_word(22'h000123)) begin
         failures++;
         $display("FAIL first_read ack=%b got=%h want=%h", ack, rdata, model_word(22'h000123));
      end
      if (m_last_addr !== 22'h000123) begin
         failures++;
         $display("FAIL first_read_addr got=%h want=000123", m_last_addr);
      end
      if (cs_edges - e0 != 1) begin
         failures++;
         $display("FAIL first_read_edges got=%0d want=1", cs_edges - e0);
      end
      req = 1'b0;
      tick();
   endtask

   task automatic test_miss_then_hit();
      logic [15:0] d;
      int lat;
      int edges;
      do_read(22'h000010, d, lat, edges);
      checks += 2;
      if (d !== 16'hBEEF) begin failures++; $display("FAIL miss_data got=%h want=beef", d); end
      if (edges != 1) begin failures++; $display("FAIL miss_edges got=%0d want=1", edges); end
      tick();
      do_read(22'h000010, d, lat, edges);
      checks += 3;
      if (d !== 16'hBEEF) begin failures++; $display("FAIL hit_data got=%h want=beef", d); end
      if (lat != 1) begin failures++; $display("FAIL hit_latency got=%0d want=1", lat); end
      if (edges != 0) begin failures++; $display("FAIL hit_edges got=%0d want=0", edges); end
      tick();
   endtask

   task automatic test_conflict();
      logic [15:0] d;
      int lat;
      int edges;
      do_read(22'h100010, d, lat, edges);
      checks += 2;
      if (d !== model_word(22'h100010)) begin
         failures++;
         $display("FAIL conflict_data got=%h want=%h", d, model_word(22'h100010));
      end
      if (edges != 1) begin failures++; $display("FAIL conflict_edges got=%0d want=1", edges); end
      tick();
      do_read(22'h000010, d, lat, edges);
      checks += 2;
      if (d !== 16'hBEEF) begin failures++; $display("FAIL evicted_data got=%h want=beef", d); end
      if (edges != 1) begin failures++; $display("FAIL evicted_edges got=%0d want=1", edges); end
      tick();
   endtask

   task automatic test_flush();
      logic [15:0] d;
      int lat;
      int edges;
      int e0;
      do_read(22'h000020, d, lat, edges);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      do_read(22'h000020, d, lat, edges);
      checks += 2;
      if (edges != 1) begin failures++; $display("FAIL flush_miss_edges got=%0d want=1", edges); end
      if (d !== model_word(22'h000020)) begin
         failures++;
         $display("FAIL flush_miss_data got=%h want=%h", d, model_word(22'h000020));
      end
      tick();
      do_read(22'h000020, d, lat, edges);
      checks++;
      if (edges != 0 || lat != 1) begin
         failures++;
         $display("FAIL refill_hit edges=%0d lat=%0d want 0 and 1", edges, lat);
      end
      tick();
      // Flush while the reader is mid-transfer.
      e0 = cs_edges;
      req  = 1'b1;
      addr = 22'h000030;
      wait_busy(1'b1);
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (ack === 1'b1) break;
         tick();
      end
      checks++;
      if (ack !== 1'b1 || rdata !== model_word(22'h000030)) begin
         failures++;
         $display("FAIL poisoned_data ack=%b got=%h want=%h", ack, rdata, model_word(22'h000030));
      end
      req = 1'b0;
      tick();
      do_read(22'h000030, d, lat, edges);
      checks++;
      if (edges != 1 || cs_edges - e0 != 2) begin
         failures++;
         $display("FAIL poisoned_refetch edges=%0d want=1", edges);
      end
      tick();
      // Flush landing exactly on the fill cycle.
      req  = 1'b1;
      addr = 22'h000040;
      wait_busy(1'b1);
      wait_busy(1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (ack !== 1'b1 || rdata !== model_word(22'h000040)) begin
         failures++;
         $display("FAIL fill_flush_data ack=%b got=%h want=%h", ack, rdata, model_word(22'h000040));
      end
      req = 1'b0;
      tick();
      do_read(22'h000040, d, lat, edges);
      checks++;
      if (edges != 1) begin failures++; $display("FAIL fill_flush_refetch got=%0d want=1", edges); end
      tick();
      // Hit and flush together: the hit is still served, then the entry is gone.
      req   = 1'b1;
      addr  = 22'h000040;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (ack !== 1'b1 || rdata !== model_word(22'h000040)) begin
         failures++;
         $display("FAIL hit_flush ack=%b got=%h want=%h", ack, rdata, model_word(22'h000040));
      end
      req = 1'b0;
      tick();
      do_read(22'h000040, d, lat, edges);
      checks++;
      if (edges != 1) begin failures++; $display("FAIL hit_flush_refetch got=%0d want=1", edges); end
      tick();
   endtask

   task automatic test_timeout();
      int hi;
      int lo;
      int acks;
      int e0;
      e0 = cs_edges;
      ignore_edges = 1;
      req  = 1'b1;
      addr = 22'h000070;
      for (int i = 0; i < 50; i++) begin
         if (flash_cs === 1'b1) break;
         tick();
      end
      hi = 0;
      while (flash_cs === 1'b1 && hi < 100) begin hi++; tick(); end
      lo = 0;
      while (flash_cs === 1'b0 && lo < 100) begin lo++; tick(); end
      checks += 2;
      if (hi != 15) begin failures++; $display("FAIL timeout_cs_high got=%0d want=15", hi); end
      if (lo != 2) begin failures++; $display("FAIL timeout_gap got=%0d want=2", lo); end
      for (int i = 0; i < 100; i++) begin
         if (ack === 1'b1) break;
         tick();
      end
      checks++;
      if (ack !== 1'b1 || rdata !== model_word(22'h000070)) begin
         failures++;
         $display("FAIL retry_data ack=%b got=%h want=%h", ack, rdata, model_word(22'h000070));
      end
      acks = (ack === 1'b1) ? 1 : 0;
      req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (ack === 1'b1) acks++;
      end
      checks += 2;
      if (acks != 1) begin failures++; $display("FAIL retry_acks got=%0d want=1", acks); end
      if (cs_edges - e0 != 2) begin
         failures++;
         $display("FAIL retry_edges got=%0d want=2", cs_edges - e0);
      end
   endtask

   task automatic test_reset_mid_transfer();
      logic [15:0] d;
      int lat;
      int edges;
      int acks;
      do_read(22'h000050, d, lat, edges);
      tick();
      req  = 1'b1;
      addr = 22'h000060;
      wait_busy(1'b1);
      tick();
      tick();
      resetn = 1'b0;
      #1;
      checks += 3;
      if (flash_cs !== 1'b0) begin failures++; $display("FAIL rst_cs got=%b want=0", flash_cs); end
      if (ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b want=0", ack); end
      if (flash_addr !== '0) begin failures++; $display("FAIL rst_addr got=%h want=0", flash_addr); end
      acks = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (ack === 1'b1) acks++;
      end
      req    = 1'b0;
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (ack === 1'b1) acks++;
      end
      checks++;
      if (acks != 0) begin failures++; $display("FAIL rst_stray_ack got=%0d want=0", acks); end
      do_read(22'h000050, d, lat, edges);
      checks++;
      if (edges != 1) begin failures++; $display("FAIL rst_invalid_edges got=%0d want=1", edges); end
      tick();
      do_read(22'h000060, d, lat, edges);
      checks += 2;
      if (edges != 1) begin failures++; $display("FAIL rst_refetch_edges got=%0d want=1", edges); end
      if (d !== model_word(22'h000060)) begin
         failures++;
         $display("FAIL rst_refetch_data got=%h want=%h", d, model_word(22'h000060));
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_miss_then_hit();
      test_conflict();
      test_flush();
      test_timeout();
      test_reset_mid_transfer();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
